// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and code-symbol helper for the K=3 rate-1/2 decoder
package viterbi_pkg;
  localparam int K = 3;
  localparam int NSTATES = 4;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  function automatic logic [1:0] exp_sym(input logic [1:0] s, input logic u);
    return {^({u, s} & G0), ^({u, s} & G1)};
  endfunction
endpackage

// File: rtl/viterbi_bmu.sv
// viterbi_bmu: Hamming branch metric between a received symbol and one codeword
module viterbi_bmu (
  input  logic [1:0] rx_sym,
  input  logic [1:0] code,
  output logic [1:0] bm
);
  logic [1:0] x;
  assign x = rx_sym ^ code;
  assign bm = {1'b0, x[1]} + {1'b0, x[0]};
endmodule

// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select with normalisation for the K=3 (7,5) Viterbi decoder
module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_sym,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        dec,
  output logic [1:0]        best_state,
  output logic [4*PM_W-1:0] pm_flat
);
  localparam logic [PM_W-1:0] INF = '1;
  localparam logic [NSTATES-1:0][PM_W-1:0] PM_INIT = {{3{INF}}, {PM_W{1'b0}}};
  logic [NSTATES-1:0][1:0] bm;
  logic [NSTATES-1:0][PM_W-1:0] pm, cur, nxt, norm;
  logic [NSTATES-1:0] dec_d;
  logic [PM_W-1:0] v01, v23, vmin;
  logic [1:0] i01, i23, imin;
  logic xfer;
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? INF : s[PM_W-1:0];
  endfunction
  assign in_ready = !out_valid | out_ready | clear;
  assign xfer = in_valid & in_ready;
  assign cur = clear ? PM_INIT : pm;
  for (genvar c = 0; c < NSTATES; c++) begin : g_bmu
    viterbi_bmu u_bmu (.rx_sym(rx_sym), .code(2'(c)), .bm(bm[c]));
  end
  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam logic [1:0] P0 = 2'((n % 2) * 2);
    localparam logic [1:0] P1 = P0 | 2'b01;
    localparam logic U = 1'(n / 2);
    logic [PM_W-1:0] c0, c1;
    assign c0 = sat_add(cur[P0], bm[exp_sym(P0, U)]);
    assign c1 = sat_add(cur[P1], bm[exp_sym(P1, U)]);
    assign dec_d[n] = c1 < c0;
    assign nxt[n] = dec_d[n] ? c1 : c0;
    assign norm[n] = nxt[n] - vmin;
  end
  assign i01 = nxt[1] < nxt[0] ? 2'd1 : 2'd0;
  assign i23 = nxt[3] < nxt[2] ? 2'd3 : 2'd2;
  assign v01 = nxt[i01];
  assign v23 = nxt[i23];
  assign imin = v23 < v01 ? i23 : i01;
  assign vmin = v23 < v01 ? v23 : v01;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm <= PM_INIT;
      pm_flat <= PM_INIT;
      dec <= '0;
      best_state <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      pm <= norm;
      pm_flat <= norm;
      dec <= dec_d;
      best_state <= imin;
      out_valid <= 1'b1;
    end else begin
      if (clear) pm <= PM_INIT;
      if (clear | out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_viterbi_acs_unit.sv
// tb_viterbi_acs_unit: directed and random checks of viterbi_acs_unit against a trellis model
module tb_viterbi_acs_unit;
  localparam int PM_W = 6;
  localparam int INF = 63;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] rx_sym = 0, best_state;
  logic [3:0] dec;
  logic [4*PM_W-1:0] pm_flat;
  int n_cmp = 0, n_err = 0;
  int mpm[4], mout[4], mdec, mbest;
  bit mov;
  always #5 clk = ~clk;
  viterbi_acs_unit #(.PM_W(PM_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .rx_sym(rx_sym), .out_valid(out_valid), .out_ready(out_ready), .dec(dec),
    .best_state(best_state), .pm_flat(pm_flat)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mflat();
    logic [31:0] f = 0;
    for (int s = 0; s < 4; s++) f[s*PM_W +: PM_W] = PM_W'(mout[s]);
    return f;
  endfunction
  task automatic model_reset();
    mpm = '{0, INF, INF, INF};
    mout = mpm;
    mdec = 0;
    mbest = 0;
    mov = 0;
  endtask
  task automatic model_acc(int sym, bit clr);
    int base[4], cand[4][2], nw[4], mn;
    base = mpm;
    if (clr) base = '{0, INF, INF, INF};
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++) begin
        int s1 = (s >> 1) & 1, s0 = s & 1;
        int code = ((u ^ s1 ^ s0) << 1) | (u ^ s0);
        int x = sym ^ code;
        int bmv = (x & 1) + ((x >> 1) & 1);
        int ns = (u << 1) | s1;
        cand[ns][s0] = (base[s] + bmv > INF) ? INF : base[s] + bmv;
      end
    mdec = 0;
    mn = INF + 1;
    for (int n = 0; n < 4; n++) begin
      bit pick = cand[n][1] < cand[n][0];
      mdec |= int'(pick) << n;
      nw[n] = pick ? cand[n][1] : cand[n][0];
      if (nw[n] < mn) begin
        mn = nw[n];
        mbest = n;
      end
    end
    for (int n = 0; n < 4; n++) mout[n] = nw[n] - mn;
    mpm = mout;
    mov = 1;
  endtask
  task automatic step(bit v, bit [1:0] sym, bit ordy, bit clr);
    bit rdy;
    in_valid = v;
    rx_sym = sym;
    out_ready = ordy;
    clear = clr;
    rdy = !mov | ordy | clr;
    #1 check("in_ready", in_ready, rdy);
    if (v && rdy) model_acc(sym, clr);
    else begin
      if (clr) mpm = '{0, INF, INF, INF};
      if (clr | ordy) mov = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, mov);
    check("dec", dec, mdec);
    check("best_state", best_state, mbest);
    check("pm_flat", pm_flat, mflat());
  endtask
  task automatic check_first();
    check("first_pm", pm_flat, {6'd63, 6'd0, 6'd63, 6'd2});
    check("first_best", best_state, 2);
    check("first_dec", dec, 0);
  endtask
  initial begin
    int good[6] = '{3, 2, 0, 1, 1, 3};
    int bad[6] = '{3, 2, 2, 1, 1, 3};
    int eb[6] = '{2, 1, 2, 3, 1, 0};
    bit [1:0] hs;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_pm", pm_flat, {6'd63, 6'd63, 6'd63, 6'd0});
    check("rst_dec", dec, 0);
    check("rst_best", best_state, 0);
    rst_n = 1;
    step(1, 2'b11, 1, 0);
    check_first();
    for (int i = 1; i < 6; i++) begin
      step(1, 2'(good[i]), 1, 0);
      check("strm_best", best_state, eb[i]);
      check("strm_pmbest", pm_flat[best_state*PM_W +: PM_W], 0);
    end
    for (int i = 0; i < 3; i++) step(1, 2'(good[i]), 1, 0);
    step(1, 2'b11, 1, 1);
    check_first();
    step(1, 2'(bad[0]), 1, 1);
    for (int i = 1; i < 6; i++) step(1, 2'(bad[i]), 1, 0);
    check("flip_best", best_state, 0);
    for (int i = 0; i < 3; i++) step(1, 2'(good[i]), 0, 0);
    for (int i = 3; i < 6; i++) step(1, 2'(good[i]), 1, 0);
    step(0, 2'b00, 1, 0);
    step(0, 2'b00, 1, 0);
    step(1, 2'b10, 1, 0);
    #2 rst_n = 0;
    #1 check("arst_out_valid", out_valid, 0);
    check("arst_pm", pm_flat, {6'd63, 6'd63, 6'd63, 6'd0});
    check("arst_dec", dec, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 2'(good[i]), 1, 0);
      check("rst_strm_best", best_state, eb[i]);
    end
    hs = 2'($urandom);
    for (int i = 0; i < 400; i++) begin
      bit v = $urandom_range(0, 3) != 0;
      bit r = $urandom_range(0, 3) != 0;
      bit c = v && $urandom_range(0, 31) == 0;
      bit take = v && (!mov | r | c);
      step(v, hs, r, c);
      if (take || !v) hs = 2'($urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/viterbi_acs_unit.md
# viterbi_acs_unit

Add-compare-select stage of the Viterbi decoder for the K=3, rate-1/2 convolutional code with generators G0=111 and G1=101. Each accepted 2-bit received symbol is compared against the expected code symbols by bitwise XOR and a ones count, giving a Hamming branch metric. The block then updates four path metrics, normalises them and emits one survivor decision bit per state. It sits between the symbol input buffer and the traceback/survivor memory, and its output feeds the traceback unit.

## Interface
- PM_W, default 6: path-metric width. Legal values are 4 to 8. INF is 2^PM_W-1.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- clear  in  1: synchronous re-initialisation of the path metrics.
- in_valid  in  1: rx_sym is valid.
- in_ready  out  1: the stage accepts rx_sym this cycle.
- rx_sym  in  2: received symbol. rx_sym[1] pairs with G0 and rx_sym[0] pairs with G1.
- out_valid  out  1: the decision word is valid.
- out_ready  in  1: the downstream stage takes the output.
- dec  out  4: dec[n] is the survivor decision for next-state n.
- best_state  out  2: index of the minimum normalised metric. Ties go to the lowest index.
- pm_flat  out  4*PM_W: normalised metrics. State s occupies bits [s*PM_W +: PM_W].

## Operation
- State numbering: state = {s1,s0}, where s1 is the most recent input bit.
- Transition: from state s with input u, next state = {u,s1}.
  - Expected c0 = u^s1^s0.
  - Expected c1 = u^s0.
- Branch metric: popcount(rx_sym ^ {c0,c1}), range 0..2.
- Predecessors of next state n: {n[0],0} and {n[0],1}.
  - Candidate = saturating add: min(pm + bm, INF).
  - dec[n] = 1 only if the s0=1 predecessor is strictly smaller. Ties select s0=0.
- Normalisation: subtract the minimum of the four new metrics from all four. At least one metric is therefore always 0.
- Initial metrics: pm[0]=0, pm[1..3]=INF.
- clear:
  - The metrics are re-initialised.
  - If a symbol is accepted in the same cycle, it is processed against the initial metrics.
  - Any unconsumed output is discarded, so out_valid is 0 next cycle unless a symbol was accepted.
- Handshake:
  - in_ready = !out_valid | out_ready | clear.
  - A transfer happens when in_valid & in_ready.
  - rx_sym is ignored when in_valid=0.

## Timing
- Latency is 1 cycle. A symbol accepted at edge N is reflected in dec, best_state, pm_flat and out_valid after edge N.
- Throughput is one symbol per cycle when out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - dec, best_state, pm_flat and the internal metrics hold.
  - in_ready=0.
- When out_valid=1 & out_ready=1 and no new symbol arrives: out_valid goes to 0 next cycle and the data outputs hold their values.
- Reset values: out_valid=0, dec=0, best_state=0, pm_flat={INF,INF,INF,0}, internal metrics at their initial values.
- Reset mid-stream forces all of the above immediately, without waiting for a clock edge.

## Structure
- Package viterbi_pkg holds:
  - constants K=3, NSTATES=4, G0=3'b111, G1=3'b101;
  - a function giving the expected {c0,c1} for (state, u).
- Sub-module viterbi_bmu: XOR plus 2-bit ones count, instantiated four times, once per codeword 00, 01, 10 and 11.
- This top level contains:
  - the ACS comparators;
  - the min-tree, shared by normalisation and best_state;
  - the metric registers;
  - the output register and handshake.

## Test plan
- Reset, then rx_sym=11 with out_ready=1 -> dec=0000, best_state=2, pm={s0:2, s1:63, s2:0, s3:63} (PM_W=6).
- Error-free encoded stream for bits 1,0,1,1,0,0, i.e. rx_sym 11,10,00,01,01,11 -> best_state 2,1,2,3,1,0 in turn, with pm[best]=0 at every step.
- Same stream with symbol 3 flipped to 10 -> best_state=0 after the final symbol, and no metric exceeds INF at any step.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and dec, pm_flat and best_state stay stable. On release, exactly one symbol is consumed per cycle, with none lost and none duplicated.
- Assert clear together with in_valid=1 and rx_sym=11 midway through the stream -> the output matches the first scenario.
- Drop rst_n asynchronously mid-stream -> out_valid=0 and pm_flat={INF,INF,INF,0} before the next clock edge. After release, the stream restarts cleanly.
